vga_framebuffer: RTL and testbench
==================================

VGA_FRAMEBUFFER -- requirements
Module: vga_framebuffer

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter BPP, default 1, bits per pixel; legal values 1, 2, 4.
REQ-004 Derived: PIX = H_ACTIVE*V_ACTIVE; ADDR_W = clog2(PIX); two buffers, each PIX x BPP bits.
REQ-005 clk  in  1  system clock; single clock domain for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 vga_h  in  11  horizontal pixel count; advances by one per clk while valid.
REQ-008 vga_v  in  11  vertical line count.
REQ-009 pixel_out  out  24  RGB {R[23:16],G[15:8],B[7:0]} for the (vga_h,vga_v) presented 3 cycles earlier.
REQ-010 read_address  out  ADDR_W  front-buffer pixel index currently being read.
REQ-011 wr_valid / wr_ready  in / out  1 / 1  pixel write handshake.
REQ-012 wr_addr  in  ADDR_W  pixel index to write in the back buffer.
REQ-013 wr_data  in  BPP  pixel value to write.
REQ-014 wr_err  out  1  one-cycle pulse when an accepted write has wr_addr >= PIX.
REQ-015 pal_we, pal_idx[BPP-1:0], pal_rgb[23:0]  in  palette entry write port.
REQ-016 swap_req  in  1  request to exchange front and back buffers.
REQ-017 swap_done  out  1  one-cycle pulse when the exchange takes effect.

Function
REQ-018 Read address is generated incrementally with no multiplier: 0 when vga_h==0 and vga_v==0; +1 per cycle while vga_h<H_ACTIVE and vga_v<V_ACTIVE; held otherwise.
REQ-019 Pipeline stages: S0 registers the address and active flag; S1 is the synchronous RAM read; S2 is the registered palette lookup; total latency is exactly 3 cycles.
REQ-020 A pixel outside the active area gives pixel_out=24'h000000, with its active flag delayed to match the pipeline.
REQ-021 Palette has 2^BPP entries x 24 bits; a pal_we write takes effect for lookups from the next cycle onward.
REQ-022 A write is accepted on a cycle where wr_valid && wr_ready; it lands in the back buffer only.
REQ-023 An accepted write with wr_addr >= PIX is discarded and pulses wr_err for one cycle.
REQ-024 Swap state machine states: IDLE, PENDING.
REQ-025 Swap transitions: IDLE->PENDING on swap_req; PENDING->IDLE on the cycle vga_h==0 and vga_v==V_ACTIVE (start of vertical blank).
REQ-026 On that PENDING->IDLE cycle, the front-select bit toggles and swap_done pulses for one cycle.
REQ-027 wr_ready=0 while in PENDING, so no write straddles a swap; wr_ready=1 in IDLE.
REQ-028 swap_req arriving while already in PENDING is absorbed; it does not cause a second swap.
REQ-029 swap_req arriving on the blank-start cycle while in IDLE enters PENDING and swaps at the next frame's blank.
REQ-030 A write and a front-buffer read to the same index never conflict, because they target different buffers.
REQ-031 Read address wrap: the counter restarts at 0 at (0,0) regardless of its prior value, so partial frames self-correct.

Reset
REQ-032 reset forces: pixel_out=0, read_address=0, pipeline active flags=0, swap FSM=IDLE, front-select=0, wr_ready=1, wr_err=0, swap_done=0.
REQ-033 Reset does not clear RAM contents.
REQ-034 Palette resets to entry 0 = 24'h000000 and all other entries = 24'hFFFFFF.
REQ-035 A write presented during reset is not accepted.
REQ-036 Reset asserted while in PENDING cancels the pending swap.

Structure
REQ-037 Shared package vga_pkg holds the H_ACTIVE/V_ACTIVE defaults, the clog2 helper and the swap-state encoding.
REQ-038 Storage is one sub-module, vga_dpram: simple dual-port, 1 write / 1 synchronous read, parameterised width and depth, depth 2*PIX with the buffer select as address MSB.

Verification
REQ-039 Write index 0 = 1, pulse swap_req, run one frame -> swap_done at (0,480); next frame pixel (0,0) gives pixel_out 24'hFFFFFF exactly 3 cycles after (0,0) is presented.
REQ-040 Drive (800,10) and (5,480) -> pixel_out=0 3 cycles later; read_address holds its value.
REQ-041 wr_addr=384000 with wr_valid -> write accepted, wr_err pulses once, RAM unchanged.
REQ-042 swap_req twice in one frame -> exactly one swap_done; wr_ready=0 from the first request until the swap.
REQ-043 BPP=2: set palette index 2 to 24'h00FF00, write pixel 799 = 2, swap -> pixel (799,0) gives 24'h00FF00.
REQ-044 reset asserted mid-frame while in PENDING -> all outputs at reset values next cycle; no swap_done at the following blank.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared defaults, width helper and swap-state encoding
// for the double-buffered VGA framebuffer.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } swap_st_e;

  // Address width for n entries, never narrower than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_dpram.sv
// Simple dual-port RAM: one write port, one registered
// read port, both on the same clock.
module vga_dpram #(
  parameter int W     = 1,
  parameter int AW    = 10,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port and synchronous read port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vga_framebuffer.sv
// Double-buffered palettised framebuffer: 3-stage scan-out
// pipeline, back-buffer writes and a blank-aligned swap.
module vga_framebuffer
  import vga_pkg::*;
#(
  parameter  int H_ACTIVE = H_ACTIVE_DEF,
  parameter  int V_ACTIVE = V_ACTIVE_DEF,
  parameter  int BPP      = 1,
  localparam int PIX      = H_ACTIVE * V_ACTIVE,
  localparam int ADDR_W   = clog2(PIX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       vga_h,
  input  logic [10:0]       vga_v,
  output logic [23:0]       pixel_out,
  output logic [ADDR_W-1:0] read_address,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BPP-1:0]    wr_data,
  output logic              wr_err,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_idx,
  input  logic [23:0]       pal_rgb,
  input  logic              swap_req,
  output logic              swap_done
);

  localparam int NPAL = 1 << BPP;
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W + 1)'(PIX);

  logic              active;
  logic              at_origin;
  logic              at_blank;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              sel0_q;
  logic              act0_q;
  logic              act1_q;
  logic [BPP-1:0]    ram_rdata;
  logic [23:0]       pal_q [NPAL];
  logic [23:0]       pix_q;
  swap_st_e          state_q;
  swap_st_e          state_d;
  logic              toggle;
  logic              front_q;
  logic              swap_done_q;
  logic              wr_err_q;
  logic              accept;
  logic              in_range;
  logic              ram_we;

  assign active    = (vga_h < H_LIM) && (vga_v < V_LIM);
  assign at_origin = (vga_h == 11'd0) && (vga_v == 11'd0);
  assign at_blank  = (vga_h == 11'd0) && (vga_v == V_LIM);

  // Scan address: restart at the origin, count active pixels.
  always_comb begin
    cur_addr = at_origin ? '0 : cnt_q;
    cnt_d    = active ? cur_addr + ADDR_W'(1) : cur_addr;
  end

  // S0: register scan address, buffer select and active flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rd_addr_q <= '0;
      sel0_q    <= 1'b0;
      act0_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rd_addr_q <= cur_addr;
      sel0_q    <= front_q;
      act0_q    <= active;
    end
  end

  assign wr_ready = (state_q == S_IDLE);
  assign accept   = wr_valid && wr_ready && !reset;
  assign in_range = {1'b0, wr_addr} < PIX_LIM;
  assign ram_we   = accept && in_range;

  vga_dpram #(
    .W    (BPP),
    .AW   (ADDR_W + 1),
    .DEPTH(2 << ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i({~front_q, wr_addr}),
    .wdata_i(wr_data),
    .raddr_i({sel0_q, rd_addr_q}),
    .rdata_o(ram_rdata)
  );

  // S1: active flag follows the RAM read.
  always_ff @(posedge clk) begin
    if (reset) act1_q <= 1'b0;
    else       act1_q <= act0_q;
  end

  // S2: palette storage and registered colour lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++)
        pal_q[i] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
      pix_q <= '0;
    end else begin
      if (pal_we) pal_q[pal_idx] <= pal_rgb;
      pix_q <= act1_q ? pal_q[ram_rdata] : 24'h000000;
    end
  end

  // Swap next-state: wait in PENDING for vertical blank start.
  always_comb begin
    state_d = state_q;
    toggle  = 1'b0;
    unique case (state_q)
      S_IDLE: if (swap_req) state_d = S_PEND;
      S_PEND: if (at_blank) begin
        state_d = S_IDLE;
        toggle  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Swap state, front select and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_q ^ toggle;
      swap_done_q <= toggle;
      wr_err_q    <= accept && !in_range;
    end
  end

  assign pixel_out    = pix_q;
  assign read_address = rd_addr_q;
  assign swap_done    = swap_done_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Randomised bench for vga_framebuffer with a frame-level
// reference model and a few pinned literal expectations.
module tb_vga_framebuffer;

  localparam int H   = 10;
  localparam int V   = 6;
  localparam int BPP = 2;
  localparam int PIX = H * V;
  localparam int AW  = $clog2(PIX);
  localparam int HT  = H + 3;
  localparam int VT  = V + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   vga_h;
  logic [10:0]   vga_v;
  logic [23:0]   pixel_out;
  logic [AW-1:0] read_address;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          wr_err;
  logic          pal_we;
  logic [1:0]    pal_idx;
  logic [23:0]   pal_rgb;
  logic          swap_req;
  logic          swap_done;

  vga_framebuffer #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .BPP     (BPP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vga_h       (vga_h),
    .vga_v       (vga_v),
    .pixel_out   (pixel_out),
    .read_address(read_address),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .pal_we      (pal_we),
    .pal_idx     (pal_idx),
    .pal_rgb     (pal_rgb),
    .swap_req    (swap_req),
    .swap_done   (swap_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          mem [2][64];
  logic [23:0] pal [4];
  bit          front, pend, model_ok;
  int          cnt;
  bit          q1_act, q2_act;
  int          q1_buf, q1_idx, q2_dat;
  logic [23:0] exp_pix;
  int          exp_addr;
  bit          exp_err, exp_done, exp_ready;

  initial begin
    model_ok = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 64; a++) mem[b][a] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        pend = 0; front = 0; cnt = 0;
        pal[0] = 24'h000000;
        for (int i = 1; i < 4; i++) pal[i] = 24'hFFFFFF;
        q1_act = 0; q2_act = 0; q1_buf = 0; q1_idx = 0; q2_dat = 0;
        exp_pix = 0; exp_addr = 0; exp_err = 0; exp_done = 0;
      end else begin
        bit act, acc;
        int idx;
        // colour leaves three edges after the pixel was presented
        exp_pix = q2_act ? pal[q2_dat] : 24'h0;
        q2_act  = q1_act;
        q2_dat  = mem[q1_buf][q1_idx];
        act = (vga_h < H) && (vga_v < V);
        idx = (vga_h == 0 && vga_v == 0) ? 0 : cnt;
        cnt = act ? idx + 1 : idx;
        q1_act = act; q1_buf = front; q1_idx = idx;
        exp_addr = idx;
        acc = wr_valid && !pend;
        exp_err = acc && (wr_addr >= PIX);
        if (acc && wr_addr < PIX) mem[front ? 0 : 1][wr_addr] = wr_data;
        exp_done = 0;
        if (pend) begin
          if (vga_h == 0 && vga_v == V) begin
            front = !front; pend = 0; exp_done = 1;
          end
        end else if (swap_req) pend = 1;
        if (pal_we) pal[pal_idx] = pal_rgb;
      end
      exp_ready = !pend;
      model_ok = 1;
    end
  end

  // Cycle-by-cycle comparison on the inactive edge.
  always @(negedge clk) begin
    if (swap_done === 1'b1) done_cnt++;
    if (model_ok) begin
      chk("pixel_out", 32'(pixel_out), 32'(exp_pix));
      chk("read_address", 32'(read_address), 32'(exp_addr));
      chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
      chk("wr_err", 32'(wr_err), 32'(exp_err));
      chk("swap_done", 32'(swap_done), 32'(exp_done));
    end
  end

  // ---------------- stimulus ----------------
  logic [23:0] cap_pix [HT*VT];
  int          cap_addr [HT*VT];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_valid = 0; pal_we = 0; swap_req = 0;
  endtask

  task automatic blank_pos();
    vga_h = 11'(H + 1); vga_v = 11'(V + 1);
  endtask

  task automatic wr(input int a, input int d);
    wr_valid = 1; wr_addr = AW'(a); wr_data = 2'(d);
    step();
    wr_valid = 0;
  endtask

  task automatic scan_frame();
    int t;
    t = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        vga_h = 11'(h); vga_v = 11'(v);
        step();
        cap_pix[t]  = pixel_out;
        cap_addr[t] = int'(read_address);
        t++;
      end
    blank_pos();
  endtask

  int d0;
  int sh, sv;

  initial begin
    reset = 1; idle_in(); blank_pos();
    pal_idx = 0; pal_rgb = 0; wr_data = 3;
    wr_valid = 1; wr_addr = AW'(62);
    step(); step();
    chk("rst pixel_out", 32'(pixel_out), 32'h0);
    chk("rst read_address", 32'(read_address), 32'h0);
    chk("rst wr_ready", 32'(wr_ready), 32'h1);
    chk("rst wr_err", 32'(wr_err), 32'h0);
    chk("rst swap_done", 32'(swap_done), 32'h0);
    reset = 0; wr_valid = 0;
    step();
    chk("no accept in reset", 32'(wr_err), 32'h0);

    // fill buffer 1, then swap it to the front
    for (int a = 0; a < PIX; a++) wr(a, int'($urandom % 4));
    swap_req = 1; step(); swap_req = 0;
    vga_h = 0; vga_v = 11'(V); step();
    chk("first swap_done", 32'(swap_done), 32'h1);
    blank_pos();

    // buffer 0: pixel 0 = 1, pixel H-1 = 2, rest 0
    for (int a = 0; a < PIX; a++)
      wr(a, (a == 0) ? 1 : (a == H - 1) ? 2 : 0);
    wr(PIX, 3);
    chk("wr_err pulse", 32'(wr_err), 32'h1);
    step();
    chk("wr_err one cycle", 32'(wr_err), 32'h0);
    pal_we = 1; pal_idx = 2; pal_rgb = 24'h00FF00; step(); pal_we = 0;

    // two requests in one frame give one swap
    swap_req = 1; step();
    chk("ready low pending", 32'(wr_ready), 32'h0);
    step();
    chk("ready low 2nd req", 32'(wr_ready), 32'h0);
    swap_req = 0;
    d0 = done_cnt;
    scan_frame();
    chk("one swap_done", 32'(done_cnt - d0), 32'h1);
    chk("ready after swap", 32'(wr_ready), 32'h1);

    scan_frame();
    chk("latency prev pixel", 32'(cap_pix[1]), 32'h0);
    chk("pixel(0,0) white", 32'(cap_pix[2]), 32'hFFFFFF);
    chk("pixel(1,0) black", 32'(cap_pix[3]), 32'h0);
    chk("pixel(H-1,0) green", 32'(cap_pix[H + 1]), 32'h00FF00);
    chk("addr at (H-1,0)", 32'(cap_addr[H - 1]), 32'(H - 1));
    chk("addr held blank", 32'(cap_addr[H + 2]), 32'(H));
    chk("addr row1 start", 32'(cap_addr[HT]), 32'(H));

    // reset while pending cancels the swap
    swap_req = 1; step(); swap_req = 0;
    vga_h = 3; vga_v = 2;
    reset = 1; step(); reset = 0;
    chk("rst2 wr_ready", 32'(wr_ready), 32'h1);
    chk("rst2 swap_done", 32'(swap_done), 32'h0);
    chk("rst2 pixel_out", 32'(pixel_out), 32'h0);
    chk("rst2 read_address", 32'(read_address), 32'h0);
    d0 = done_cnt;
    scan_frame();
    chk("no swap after rst", 32'(done_cnt - d0), 32'h0);

    // randomised traffic checked by the model
    sh = 0; sv = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom % 100);
      if (r < 4) begin
        vga_h = 11'($urandom_range(2047, H));
        vga_v = 11'($urandom % 2048);
      end else begin
        if (r < 6) begin sh = 0; sv = 0; end
        vga_h = 11'(sh); vga_v = 11'(sv);
        sh++;
        if (sh == HT) begin
          sh = 0; sv++;
          if (sv == VT) sv = 0;
        end
      end
      wr_valid = ($urandom % 3) == 0;
      wr_addr  = AW'($urandom % 64);
      wr_data  = 2'($urandom % 4);
      pal_we   = ($urandom % 20) == 0;
      pal_idx  = 2'($urandom % 4);
      pal_rgb  = 24'($urandom);
      swap_req = ($urandom % 30) == 0;
      reset    = ($urandom % 500) == 0;
      step();
    end
    reset = 0; idle_in(); blank_pos();
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
